// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers the raster position from hsync/vsync, measures line and frame timing against nominal values, and tracks lock
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             err_clr,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked,
  output logic             err_pulse,
  output logic [3:0]       err_flags
);
  localparam logic             ACT    = (SYNC_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_NOM  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_NOM  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(2 * H_TOTAL);
  localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(2 * V_TOTAL);
  localparam logic [CNT_W-1:0] HS_NOM = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_NOM = CNT_W'(V_SYNC * H_TOTAL);
  localparam logic [CNT_W-1:0] LK_NOM = CNT_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             hs_d_q, vs_d_q, hv_q, hv_d, vv_q, vv_d, meas_q, meas_d, fe_q, fe_d, pulse_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, len_q, len_d, fl_q, fl_d;
  logic [CNT_W-1:0] hw_q, hw_d, vw_q, vw_d, good_q, good_d, fl_new;
  logic [3:0]       flags_q, flags_d, new_err;
  logic             hs_a, vs_a, ls, fs, he, ve;
  logic             line_bad, width_bad, frame_bad, frame_ok, timeout;

  assign hs_a = hsync ^ ACT;
  assign vs_a = vsync ^ ACT;
  assign ls   = hs_a & ~hs_d_q;
  assign fs   = vs_a & ~vs_d_q;
  assign he   = ~hs_a & hs_d_q;
  assign ve   = ~vs_a & vs_d_q;

  // A line start coinciding with the frame start is counted in the ending frame
  assign fl_new    = v_cnt_q + (ls ? ONE : '0);
  assign line_bad  = ls & meas_q & ((h_cnt_q + ONE) != H_NOM);
  assign width_bad = (he & hv_q & (hw_q != HS_NOM)) | (ve & vv_q & (vw_q != VS_NOM));
  assign frame_bad = fs & (state_q != SEARCH) & (fl_new != V_NOM);
  assign frame_ok  = ~fe_q & ~line_bad & ~width_bad & (fl_new == V_NOM);
  // Fires only on the cycle a counter reaches saturation, not while it sits there
  assign timeout   = (~ls & (h_cnt_q == H_MAX - ONE)) | (ls & ~fs & (v_cnt_q == V_MAX - ONE));
  assign new_err   = {timeout, width_bad, frame_bad, line_bad};

  always_comb begin
    h_cnt_d = ls ? '0 : (h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + ONE;
    v_cnt_d = fs ? '0 : (ls && v_cnt_q != V_MAX) ? v_cnt_q + ONE : v_cnt_q;
    len_d   = (ls && meas_q) ? h_cnt_q + ONE : len_q;
    fl_d    = fs ? fl_new : fl_q;
    hw_d    = ls ? ONE : (hs_a && hw_q != '1) ? hw_q + ONE : hw_q;
    vw_d    = fs ? ONE : (vs_a && vw_q != '1) ? vw_q + ONE : vw_q;
    hv_d    = ls | (hv_q & ~he);
    vv_d    = fs | (vv_q & ~ve);
    meas_d  = timeout ? 1'b0 : (meas_q | ls);
    fe_d    = fs ? 1'b0 : (fe_q | line_bad | width_bad);
    flags_d = (err_clr ? 4'b0 : flags_q) | new_err;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: if (fs) begin
        state_d = ACQUIRE;
        good_d  = '0;
      end
      ACQUIRE: if (fs) begin
        good_d  = frame_ok ? good_q + ONE : '0;
        state_d = (frame_ok && good_q + ONE >= LK_NOM) ? LOCKED : ACQUIRE;
      end
      LOCKED: if (line_bad || width_bad || (fs && !frame_ok)) begin
        state_d = ACQUIRE;
        good_d  = '0;
      end
      default: state_d = SEARCH;
    endcase
    if (timeout) begin
      state_d = SEARCH;
      good_d  = '0;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      hs_d_q  <= 1'b0;
      vs_d_q  <= 1'b0;
      hv_q    <= 1'b0;
      vv_q    <= 1'b0;
      meas_q  <= 1'b0;
      fe_q    <= 1'b0;
      pulse_q <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      len_q   <= '0;
      fl_q    <= '0;
      hw_q    <= '0;
      vw_q    <= '0;
      good_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      hs_d_q  <= hs_a;
      vs_d_q  <= vs_a;
      hv_q    <= hv_d;
      vv_q    <= vv_d;
      meas_q  <= meas_d;
      fe_q    <= fe_d;
      pulse_q <= |new_err;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      len_q   <= len_d;
      fl_q    <= fl_d;
      hw_q    <= hw_d;
      vw_q    <= vw_d;
      good_q  <= good_d;
      flags_q <= flags_d;
    end
  end

  assign h_pos       = h_cnt_q;
  assign v_pos       = v_cnt_q;
  assign line_len    = len_q;
  assign frame_lines = fl_q;
  assign locked      = (state_q == LOCKED);
  assign err_pulse   = pulse_q;
  assign err_flags   = flags_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed raster stimulus on a scaled-down 40x12 timing, checked against hand-computed values
module tb_vga_timing_monitor;
  localparam int H = 40, V = 12, HS = 6, VS = 2;

  logic        vga_clk = 1'b0, rst_n = 1'b0, hsync = 1'b1, vsync = 1'b1, err_clr = 1'b0;
  logic [15:0] h_pos, v_pos, line_len, frame_lines;
  logic        locked, err_pulse;
  logic [3:0]  err_flags;
  int          n_pass = 0, n_chk = 0;

  // per-line snapshots taken one cycle after each line start
  logic [15:0] a_len[16], a_fl[16], a_vp[16], a_hp[16];
  logic        a_lk[16];
  logic [3:0]  a_fg[16];
  int          a_pl[16];

  always #5 vga_clk = ~vga_clk;

  vga_timing_monitor #(
    .H_TOTAL(H), .V_TOTAL(V), .H_SYNC(HS), .V_SYNC(VS),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2), .CNT_W(16)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .err_clr(err_clr),
    .h_pos(h_pos), .v_pos(v_pos), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .err_pulse(err_pulse), .err_flags(err_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic line(input int idx, input int len, input int hw, input bit clr);
    a_pl[idx] = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge vga_clk);
      a_pl[idx] += int'(err_pulse);
      if (i == 1) begin
        a_len[idx] = line_len;
        a_fl[idx]  = frame_lines;
        a_vp[idx]  = v_pos;
        a_hp[idx]  = h_pos;
        a_lk[idx]  = locked;
        a_fg[idx]  = err_flags;
      end
      hsync   = (i < hw) ? 1'b0 : 1'b1;
      vsync   = (idx < VS) ? 1'b0 : 1'b1;
      err_clr = clr && (i == 5);
    end
  endtask

  task automatic frame(input int nl, input int bad_l, input int bad_len, input int bad_hw, input int clr_l);
    for (int l = 0; l < nl; l++)
      line(l, (l == bad_l) ? bad_len : H, (l == bad_l) ? bad_hw : HS, l == clr_l);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge vga_clk);
    check("rst_hpos", h_pos, 0);
    check("rst_vpos", v_pos, 0);
    check("rst_len", line_len, 0);
    check("rst_fl", frame_lines, 0);
    check("rst_lock", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_flags", err_flags, 0);
    rst_n = 1'b1;
    for (int l = 5; l < V; l++) line(l, H, HS, 0);
    frame(V, -1, H, HS, -1);
    check("a_lock", a_lk[0], 0);
    check("a_hpos", a_hp[0], 0);
    frame(V, -1, H, HS, -1);
    check("b_lock", a_lk[0], 0);
    frame(V, -1, H, HS, -1);
    check("c_lock", a_lk[0], 1);
    check("c_len", a_len[0], H);
    check("c_fl", a_fl[0], V);
    check("c_flags", a_fg[0], 0);
    check("c_vpos", a_vp[0], 0);
    frame(V, 5, H - 1, HS, -1);
    check("short_prelock", a_lk[4], 1);
    check("short_len", a_len[6], H - 1);
    check("short_pulse", a_pl[6], 1);
    check("short_flags", a_fg[6], 4'b0001);
    check("short_lock", a_lk[6], 0);
    frame(V, -1, H, HS, -1);
    check("e_lock", a_lk[0], 0);
    frame(V, -1, H, HS, -1);
    check("f_lock", a_lk[0], 0);
    frame(V - 1, -1, H, HS, 2);
    check("relock", a_lk[0], 1);
    check("clr1_flags", a_fg[3], 0);
    frame(V, -1, H, HS, 0);
    check("fr_fl", a_fl[0], V - 1);
    check("fr_flags", a_fg[0], 4'b0010);
    check("fr_lock", a_lk[0], 0);
    check("fr_pulse", a_pl[0], 1);
    check("fr_clr", a_fg[1], 0);
    frame(V, -1, H, HS, -1);
    check("i_lock", a_lk[0], 0);
    frame(V, -1, H, HS, -1);
    check("j_lock", a_lk[0], 1);
    check("j_fl", a_fl[0], V);
    check("j_vpos", a_vp[0], 0);
    frame(V, -1, H, HS, -1);
    check("k_lock", a_lk[0], 1);
    check("k_fl", a_fl[0], V);
    check("k_vpos", a_vp[0], 0);
    check("k_flags", a_fg[0], 0);
    for (int l = 0; l < 4; l++) line(l, H, HS, 0);
    check("to_prelock", locked, 1);
    hsync = 1'b1;
    vsync = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 4 * H && !hit; i++) begin
      @(negedge vga_clk);
      hit = (h_pos == 16'(2 * H));
    end
    check("to_hpos", h_pos, 2 * H);
    check("to_lock", locked, 0);
    check("to_pulse", err_pulse, 1);
    check("to_flags", err_flags, 4'b1000);
    repeat (5) @(negedge vga_clk);
    check("to_hold", h_pos, 2 * H);
    check("to_pulse1", err_pulse, 0);
    frame(V, -1, H, HS, 0);
    check("m_lock", a_lk[0], 0);
    frame(V, -1, H, HS, -1);
    check("n_lock", a_lk[0], 0);
    frame(V, 5, H, HS - 1, -1);
    check("o_lock", a_lk[0], 1);
    check("o_flags", a_fg[0], 0);
    check("w_flags", a_fg[6], 4'b0100);
    check("w_lock", a_lk[6], 0);
    check("w_pulse", a_pl[5], 1);
    check("w_len", a_len[6], H);
    repeat (10) @(negedge vga_clk);
    check("pre_rst_len", line_len, H);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hpos", h_pos, 0);
    check("arst_vpos", v_pos, 0);
    check("arst_len", line_len, 0);
    check("arst_fl", frame_lines, 0);
    check("arst_lock", locked, 0);
    check("arst_pulse", err_pulse, 0);
    check("arst_flags", err_flags, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
